// File: rtl/gpr_wport_arbiter_if.sv
// Write-port arbitration bundle: writeback and secondary result requests in,
// register-file write port, stall request and pending-write mask out.
interface gpr_wport_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic [4:0]        lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              gpr_we;
    logic [4:0]        gpr_a3;
    logic [DATA_W-1:0] gpr_wd;
    logic              stall_req;
    logic [31:0]       pend_mask;

    modport master (
        output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        input  lu_ready, gpr_we, gpr_a3, gpr_wd, stall_req, pend_mask
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        output lu_ready, gpr_we, gpr_a3, gpr_wd, stall_req, pend_mask
    );
endinterface

// File: rtl/gpr_wport_arbiter.sv
// Shares the GPR write port between writeback (always wins) and an in-order
// FIFO of long-latency results, with WAW kill, starvation bubble and pending mask.
module gpr_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int DATA_W     = 32
) (
    input logic                Clk,
    input logic                Rst,
    gpr_wport_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);

    logic [4:0]        addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]  occ_r;
    logic [DEPTH-1:0]  kill_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [STV_W-1:0]  starve_r;
    logic [31:0]       pend_r;

    logic              full_s;
    logic              empty_s;
    logic              head_live_s;
    logic              grant_wb_s;
    logic              lu_ready_s;
    logic              enq_s;
    logic              pop_s;
    logic              gpr_we_s;
    logic [4:0]        gpr_a3_s;
    logic [DATA_W-1:0] gpr_wd_s;
    logic [DEPTH-1:0]  occ_nx_s;
    logic [DEPTH-1:0]  kill_nx_s;
    logic [31:0]       pend_nx_s;
    logic [CNT_W-1:0]  count_nx_s;
    logic [STV_W-1:0]  starve_nx_s;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign head_live_s = !empty_s && !kill_r[rd_ptr_r];
    assign grant_wb_s  = !Rst && bus.wb_we && (bus.wb_addr != 5'd0);
    assign lu_ready_s  = !Rst && !full_s;
    assign enq_s       = bus.lu_valid && lu_ready_s && (bus.lu_addr != 5'd0);

    assign bus.lu_ready  = lu_ready_s;
    assign bus.gpr_we    = gpr_we_s;
    assign bus.gpr_a3    = gpr_a3_s;
    assign bus.gpr_wd    = gpr_wd_s;
    assign bus.pend_mask = pend_r;
    assign bus.stall_req = !Rst && head_live_s && (starve_r == STV_LAST);

    // Port select: writeback first, otherwise drain the FIFO head (killed heads pop silently)
    always_comb begin
        gpr_we_s = 1'b0;
        gpr_a3_s = 5'd0;
        gpr_wd_s = {DATA_W{1'b0}};
        pop_s    = 1'b0;
        if (grant_wb_s) begin
            gpr_we_s = 1'b1;
            gpr_a3_s = bus.wb_addr;
            gpr_wd_s = bus.wb_data;
        end else if (!Rst && !empty_s) begin
            pop_s = 1'b1;
            if (!kill_r[rd_ptr_r]) begin
                gpr_we_s = 1'b1;
                gpr_a3_s = addr_r[rd_ptr_r];
                gpr_wd_s = data_r[rd_ptr_r];
            end else begin
                gpr_we_s = 1'b0;
            end
        end else begin
            gpr_we_s = 1'b0;
        end
    end

    // Next FIFO occupancy/kill state; pend mask is built from it so it lines up with the new state
    always_comb begin
        occ_nx_s  = occ_r;
        kill_nx_s = kill_r;
        pend_nx_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nx_s[i]  = occ_r[i] && !(pop_s && (rd_ptr_r == PTR_W'(i)));
            kill_nx_s[i] = kill_r[i] || (grant_wb_s && (addr_r[i] == bus.wb_addr));
            if (enq_s && (wr_ptr_r == PTR_W'(i))) begin
                occ_nx_s[i]  = 1'b1;
                kill_nx_s[i] = grant_wb_s && (bus.wb_addr == bus.lu_addr);
            end else begin
                occ_nx_s[i]  = occ_nx_s[i];
            end
            pend_nx_s = pend_nx_s |
                ((occ_nx_s[i] && !kill_nx_s[i])
                    ? (32'd1 << ((enq_s && (wr_ptr_r == PTR_W'(i))) ? bus.lu_addr : addr_r[i]))
                    : 32'd0);
        end
        pend_nx_s[0] = 1'b0;
        count_nx_s   = count_r + CNT_W'(enq_s) - CNT_W'(pop_s);
    end

    // Starvation age of a live head that keeps losing the port to writeback
    always_comb begin
        if (empty_s || pop_s) begin
            starve_nx_s = {STV_W{1'b0}};
        end else if (head_live_s && grant_wb_s && (starve_r != STV_LAST)) begin
            starve_nx_s = starve_r + STV_W'(1);
        end else begin
            starve_nx_s = starve_r;
        end
    end

    // State registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= 5'd0;
                data_r[i] <= {DATA_W{1'b0}};
            end
            occ_r    <= {DEPTH{1'b0}};
            kill_r   <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            starve_r <= {STV_W{1'b0}};
            pend_r   <= 32'd0;
        end else begin
            if (enq_s) begin
                addr_r[wr_ptr_r] <= bus.lu_addr;
                data_r[wr_ptr_r] <= bus.lu_data;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r    <= occ_nx_s;
            kill_r   <= kill_nx_s;
            count_r  <= count_nx_s;
            starve_r <= starve_nx_s;
            pend_r   <= pend_nx_s;
        end
    end
endmodule
